// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-bank write port between NUM_REQ writeback sources.
// Optional dropped-write counter enabled by defining RF_ARB_DROP_CNT_EN.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int PROT_HI = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      rf_stall,
  output logic                      rf_reg_write,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_write_data,
  output logic [2:0]                grant_id,
  output logic                      drop_pulse,
  output logic [15:0]               pend_mask,
  output logic [15:0]               drop_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, HOLD = 2'd2} state_t;

  state_t              state_r, state_nxt_s;
  logic [2:0]          rr_ptr_r, rr_nxt_s;
  logic [ADDR_W-1:0]   rf_rd_r;
  logic [DATA_W-1:0]   rf_data_r;
  logic [2:0]          grant_id_r;
  logic                drop_pulse_r;
  logic [7:0]          valid_ext_s;
  logic [ADDR_W-1:0]   rd_arr_s   [8];
  logic [DATA_W-1:0]   data_arr_s [8];
  logic [3:0]          scan_s;
  logic                found_s, grant_vld_s, prot_s;
  logic [2:0]          grant_idx_s;
  logic [ADDR_W-1:0]   grant_rd_s;
  logic [7:0]          ready_ext_s;

  // Widen requester vectors to 8 slots so a 3-bit index always selects exactly.
  for (genvar i = 0; i < 8; i++) begin : g_unpack
    if (i < NUM_REQ) begin : g_used
      assign valid_ext_s[i] = req_valid[i];
      assign rd_arr_s[i]    = req_rd[i*ADDR_W +: ADDR_W];
      assign data_arr_s[i]  = req_data[i*DATA_W +: DATA_W];
    end else begin : g_unused
      assign valid_ext_s[i] = 1'b0;
      assign rd_arr_s[i]    = '0;
      assign data_arr_s[i]  = '0;
    end
  end

  // Round-robin scan starting at rr_ptr; nothing is granted while the bank stalls.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = 3'd0;
    scan_s      = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_s = {1'b0, rr_ptr_r} + 4'(k);
      if (scan_s >= 4'(NUM_REQ)) begin
        scan_s = scan_s - 4'(NUM_REQ);
      end else begin
        scan_s = scan_s;
      end
      if (!found_s && valid_ext_s[scan_s[2:0]]) begin
        found_s     = 1'b1;
        grant_idx_s = scan_s[2:0];
      end else begin
        found_s     = found_s;
      end
    end
    grant_vld_s = found_s && !rf_stall;
    grant_rd_s  = rd_arr_s[grant_idx_s];
    prot_s      = (grant_rd_s == ADDR_W'(0)) || (grant_rd_s == ADDR_W'(PROT_HI));
    rr_nxt_s    = (grant_idx_s == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx_s + 3'd1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a stall parks a pending write in HOLD, otherwise the grant decides.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (rf_stall)                     state_nxt_s = IDLE;
        else if (grant_vld_s && !prot_s)  state_nxt_s = WRITE;
        else                              state_nxt_s = IDLE;
      end
      WRITE, HOLD: begin
        if (rf_stall)                     state_nxt_s = HOLD;
        else if (grant_vld_s && !prot_s)  state_nxt_s = WRITE;
        else                              state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: write enable decoded from state, grant handshake and hazard mask.
  always_comb begin
    rf_reg_write = (state_r == WRITE) || (state_r == HOLD);
    ready_ext_s  = grant_vld_s ? (8'd1 << grant_idx_s) : 8'd0;
    req_ready    = ready_ext_s[NUM_REQ-1:0];
    pend_mask    = rf_reg_write ? (16'd1 << rf_rd_r) : 16'd0;
  end

  // Write datapath and round-robin pointer; a dropped write leaves rd/data/grant_id untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r     <= 3'd0;
      rf_rd_r      <= '0;
      rf_data_r    <= '0;
      grant_id_r   <= 3'd0;
      drop_pulse_r <= 1'b0;
    end else if (grant_vld_s) begin
      rr_ptr_r     <= rr_nxt_s;
      drop_pulse_r <= prot_s;
      if (!prot_s) begin
        rf_rd_r    <= grant_rd_s;
        rf_data_r  <= data_arr_s[grant_idx_s];
        grant_id_r <= grant_idx_s;
      end else begin
        rf_rd_r    <= rf_rd_r;
      end
    end else begin
      drop_pulse_r <= 1'b0;
    end
  end

  assign rf_rd         = rf_rd_r;
  assign rf_write_data = rf_data_r;
  assign grant_id      = grant_id_r;
  assign drop_pulse    = drop_pulse_r;

`ifdef RF_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt_r;

  // Saturating count of writes filtered for targeting a protected register.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 16'h0000;
    end else if (grant_vld_s && prot_s && (drop_cnt_r != 16'hFFFF)) begin
      drop_cnt_r <= drop_cnt_r + 16'h0001;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_cnt = drop_cnt_r;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed + random bench for rf_wb_arbiter with a round-robin reference model and write scoreboard.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [11:0] req_rd;
  logic [95:0] req_data;
  logic        rf_stall;
  logic        rf_reg_write;
  logic [3:0]  rf_rd;
  logic [31:0] rf_write_data;
  logic [2:0]  grant_id;
  logic        drop_pulse;
  logic [15:0] pend_mask;
  logic [15:0] drop_cnt;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .rf_stall(rf_stall),
    .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .grant_id(grant_id), .drop_pulse(drop_pulse), .pend_mask(pend_mask),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RF_ARB_DROP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
    logic [2:0]  gid;
  } wr_t;

  wr_t         sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [2:0]  m_ptr = 3'd0;
  logic        m_we = 1'b0, m_drop = 1'b0, new_wr = 1'b0;
  logic [3:0]  m_rd = 4'd0;
  logic [31:0] m_data = 32'd0;
  logic [2:0]  m_gid = 3'd0;
  logic [15:0] m_cnt = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check the combinational grant, advance the model, check registered outputs.
  task automatic tick(input string tag);
    logic       found;
    logic [2:0] g, idx;
    logic [3:0] rd;
    wr_t        e;
    #1;
    found = 1'b0;
    g     = 3'd0;
    if (!rf_stall) begin
      for (int k = 0; k < 3; k++) begin
        idx = 3'((int'(m_ptr) + k) % 3);
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
    end
    if (!rst) chk({tag, ".ready"}, {29'd0, req_ready}, found ? (32'd1 << g) : 32'd0);
    new_wr = 1'b0;
    if (rst) begin
      m_ptr = 3'd0; m_we = 1'b0; m_drop = 1'b0; m_rd = 4'd0;
      m_data = 32'd0; m_gid = 3'd0; m_cnt = 16'd0;
      sb.delete();
    end else if (rf_stall) begin
      m_drop = 1'b0;
    end else if (found) begin
      m_ptr = (g == 3'd2) ? 3'd0 : g + 3'd1;
      rd = req_rd[g*4 +: 4];
      if (rd == 4'd0 || rd == 4'd15) begin
        m_we   = 1'b0;
        m_drop = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        sb.push_back('{rd: rd, data: req_data[g*32 +: 32], gid: g});
        m_we   = 1'b1;
        m_drop = 1'b0;
        new_wr = 1'b1;
      end
    end else begin
      m_we   = 1'b0;
      m_drop = 1'b0;
    end
    @(posedge clk);
    #1;
    if (new_wr) begin
      e = sb.pop_front();
      chk({tag, ".sb_rd"},   {28'd0, rf_rd},   {28'd0, e.rd});
      chk({tag, ".sb_data"}, rf_write_data,    e.data);
      chk({tag, ".sb_gid"},  {29'd0, grant_id}, {29'd0, e.gid});
      m_rd = e.rd; m_data = e.data; m_gid = e.gid;
    end
    chk({tag, ".we"},   {31'd0, rf_reg_write}, {31'd0, m_we});
    chk({tag, ".drop"}, {31'd0, drop_pulse},   {31'd0, m_drop});
    chk({tag, ".rd"},   {28'd0, rf_rd},        {28'd0, m_rd});
    chk({tag, ".data"}, rf_write_data,         m_data);
    chk({tag, ".gid"},  {29'd0, grant_id},     {29'd0, m_gid});
    chk({tag, ".pend"}, {16'd0, pend_mask},    m_we ? (32'd1 << m_rd) : 32'd0);
    chk({tag, ".cnt"},  {16'd0, drop_cnt},     CNT_EN ? {16'd0, m_cnt} : 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 3'b000; req_rd = 12'd0; req_data = 96'd0; rf_stall = 1'b0;
    @(negedge clk);
    tick("reset0");
    tick("reset1");
    rst = 1'b0;
    tick("idle");

    // Basic single write from requester 0.
    req_valid = 3'b001; req_rd = {4'd0, 4'd0, 4'd5}; req_data = {32'd0, 32'd0, 32'hDEADBEEF};
    tick("basic");
    chk("basic.pend_exact", {16'd0, pend_mask}, 32'h0000_0020);
    req_valid = 3'b000;
    tick("basic_idle");

    // Round-robin with all requesters valid.
    req_valid = 3'b111; req_rd = {4'd3, 4'd2, 4'd1};
    req_data  = {32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0};
    for (int c = 0; c < 6; c++) tick("rr");

    // Protected destinations R0 and R15 are accepted but dropped.
    req_valid = 3'b010; req_rd = {4'd0, 4'd0, 4'd0};
    tick("prot_r0");
    req_rd = {4'd0, 4'd15, 4'd0};
    tick("prot_r15");
    req_valid = 3'b000;
    tick("prot_idle");

    // Stall holds a pending write while requester 2 waits.
    req_valid = 3'b001; req_rd = {4'd9, 4'd0, 4'd7}; req_data = {32'h22, 32'd0, 32'h11};
    tick("stall_grant");
    req_valid = 3'b100; rf_stall = 1'b1;
    for (int c = 0; c < 3; c++) tick("stall_hold");
    rf_stall = 1'b0;
    tick("stall_release");
    req_valid = 3'b000;
    tick("stall_idle");

    // Reset while holding discards the write and rewinds the pointer.
    req_valid = 3'b001; req_rd = {4'd0, 4'd0, 4'd4}; req_data = {32'd0, 32'd0, 32'h33};
    tick("hold_grant");
    req_valid = 3'b000; rf_stall = 1'b1;
    tick("hold_stall");
    rst = 1'b1;
    tick("hold_reset");
    rst = 1'b0; rf_stall = 1'b0; req_valid = 3'b110;
    req_rd = {4'd12, 4'd11, 4'd10}; req_data = {32'hC2, 32'hC1, 32'hC0};
    tick("post_reset");
    req_valid = 3'b000;
    tick("post_idle");

    // Random traffic including stalls and protected targets.
    for (int c = 0; c < 60; c++) begin
      req_valid = 3'($urandom_range(0, 7));
      req_rd    = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      req_data  = {$urandom, $urandom, $urandom};
      rf_stall  = ($urandom_range(0, 3) == 0);
      tick("rand");
    end
    rf_stall = 1'b0; req_valid = 3'b000;
    tick("rand_idle");

`ifdef RF_ARB_DROP_CNT_EN
    // Counter saturation starting near the top.
    force dut.drop_cnt_r = 16'hFFFE;
    #1;
    release dut.drop_cnt_r;
    m_cnt = 16'hFFFE;
    req_valid = 3'b001; req_rd = {4'd0, 4'd0, 4'd15};
    for (int c = 0; c < 3; c++) tick("sat");
    req_valid = 3'b000;
    tick("sat_idle");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
